// File: rtl/aer_frame_encoder.sv
// Transmit end of the four-channel AER link: latches channel events, arbitrates
// round-robin, and sends each one as a 5-token frame using four-phase handshakes.
module aer_frame_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ch1Up,
  input  logic             Ch1Down,
  input  logic             Ch2Up,
  input  logic             Ch2Down,
  output logic             Fs,
  output logic             X0,
  output logic             Zero,
  output logic             One,
  output logic             Fe,
  input  logic             Fs_ack,
  input  logic             X0_ack,
  input  logic             Zero_ack,
  input  logic             One_ack,
  input  logic             Fe_ack,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] frames_sent
);

  // Fewer than two stages would not give a metastable ack time to settle.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // Bit positions of each token wire within the token and ack vectors.
  localparam int TK_FS   = 0;
  localparam int TK_X0   = 1;
  localparam int TK_ZERO = 2;
  localparam int TK_ONE  = 3;
  localparam int TK_FE   = 4;

  // Event codes: 0 Ch1Up, 1 Ch1Down, 2 Ch2Up, 3 Ch2Down.
  // Bit 1 selects the channel, bit 0 set means Down.
  logic [1:0]       state;
  logic [2:0]       tok_idx;
  logic [1:0]       cur_evt;
  logic [4:0]       tok_q;
  logic [3:0]       pending;
  logic [1:0]       rr_ptr;
  logic [4:0]       ack_pipe [SYNC_N];
  logic [4:0]       ack_s;
  logic [4:0]       ack_raw;
  logic [3:0]       pulses;
  logic             grant_valid;
  logic [1:0]       grant_evt;
  logic [1:0]       cand;
  logic [3:0]       grant_vec;
  logic [4:0]       cur_sel;
  logic             cur_ack;

  assign pulses  = {Ch2Down, Ch2Up, Ch1Down, Ch1Up};
  assign ack_raw = {Fe_ack, One_ack, Zero_ack, X0_ack, Fs_ack};

  // One-hot token wire for position idx of the frame carrying event evt.
  function automatic logic [4:0] token_sel(input logic [2:0] idx, input logic [1:0] evt);
    logic [4:0] sel;
    sel = '0;
    case (idx)
      3'd0:    sel[TK_FS] = 1'b1;
      3'd1:    sel[evt[1] ? TK_ONE : TK_ZERO] = 1'b1;
      3'd2:    sel[TK_X0] = 1'b1;
      3'd3:    sel[evt[0] ? TK_ZERO : TK_ONE] = 1'b1;
      default: sel[TK_FE] = 1'b1;
    endcase
    return sel;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_N; i++) ack_pipe[i] <= '0;
    end else begin
      ack_pipe[0] <= ack_raw;
      for (int i = 1; i < SYNC_N; i++) ack_pipe[i] <= ack_pipe[i-1];
    end
  end

  assign ack_s = ack_pipe[SYNC_N-1];

  // Round-robin search: walk downward so the candidate nearest rr_ptr wins.
  // NOTE: every combinational output gets a default before any branch,
  // otherwise an unassigned path would infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_evt   = rr_ptr;
    cand        = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_evt   = cand;
      end
    end
  end

  assign grant_vec = (state == IDLE && grant_valid) ? (4'b0001 << grant_evt) : 4'b0000;

  assign cur_sel = token_sel(tok_idx, cur_evt);
  assign cur_ack = |(cur_sel & ack_s);

  // A pulse coinciding with its own grant re-arms the flag; otherwise a pulse
  // on an already-set flag is a lost event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pulses | (pending & ~grant_vec);
      overflow <= overflow | (|(pulses & pending & ~grant_vec));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      tok_idx     <= '0;
      cur_evt     <= '0;
      tok_q       <= '0;
      rr_ptr      <= '0;
      frames_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_evt <= grant_evt;
            rr_ptr  <= grant_evt + 2'd1;
            tok_idx <= 3'd0;
            tok_q   <= token_sel(3'd0, grant_evt);
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (cur_ack) begin
            tok_q <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!cur_ack) begin
            if (tok_idx < 3'd4) begin
              tok_idx <= tok_idx + 3'd1;
              tok_q   <= token_sel(tok_idx + 3'd1, cur_evt);
              state   <= ASSERT;
            end else begin
              frames_sent <= frames_sent + CNT_W'(1);
              state       <= IDLE;
            end
          end
        end
        default: begin
          tok_q <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign Fs   = tok_q[TK_FS];
  assign X0   = tok_q[TK_X0];
  assign Zero = tok_q[TK_ZERO];
  assign One  = tok_q[TK_ONE];
  assign Fe   = tok_q[TK_FE];

endmodule

// File: tb/tb_aer_frame_encoder.sv
// Directed bench for aer_frame_encoder: a receiver model acks tokens with a
// 3-cycle lag, and observed token sequences are compared to hand-written frames.
module tb_aer_frame_encoder;

  localparam int CNT_W = 16;

  // Token ids: Fs=0, X0=1, Zero=2, One=3, Fe=4; first token in the MSBs.
  localparam logic [14:0] F_CH1UP   = {3'd0, 3'd2, 3'd1, 3'd3, 3'd4};
  localparam logic [14:0] F_CH1DOWN = {3'd0, 3'd2, 3'd1, 3'd2, 3'd4};
  localparam logic [14:0] F_CH2UP   = {3'd0, 3'd3, 3'd1, 3'd3, 3'd4};
  localparam logic [14:0] F_CH2DOWN = {3'd0, 3'd3, 3'd1, 3'd2, 3'd4};

  logic             clk;
  logic             reset;
  logic [3:0]       ev;
  logic [4:0]       tok;
  logic [4:0]       auto_q;
  logic [4:0]       man_ack;
  logic [4:0]       acks;
  logic             auto_ack;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] frames_sent;

  int         n_chk;
  int         n_err;
  int         prot_err;
  logic [2:0] seen[$];
  logic [4:0] prev_tok;
  int         lag_cnt [5];

  assign acks = auto_q | man_ack;

  aer_frame_encoder #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Ch1Up      (ev[0]),
    .Ch1Down    (ev[1]),
    .Ch2Up      (ev[2]),
    .Ch2Down    (ev[3]),
    .Fs         (tok[0]),
    .X0         (tok[1]),
    .Zero       (tok[2]),
    .One        (tok[3]),
    .Fe         (tok[4]),
    .Fs_ack     (acks[0]),
    .X0_ack     (acks[1]),
    .Zero_ack   (acks[2]),
    .One_ack    (acks[3]),
    .Fe_ack     (acks[4]),
    .busy       (busy),
    .overflow   (overflow),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Receiver model: each ack follows its token after three stable cycles.
  always @(negedge clk) begin
    for (int t = 0; t < 5; t++) begin
      if (!auto_ack) begin
        lag_cnt[t] = 0;
        auto_q[t]  = 1'b0;
      end else if (tok[t] != auto_q[t]) begin
        lag_cnt[t] = lag_cnt[t] + 1;
        if (lag_cnt[t] == 3) begin
          auto_q[t]  = tok[t];
          lag_cnt[t] = 0;
        end
      end else begin
        lag_cnt[t] = 0;
      end
    end
  end

  // Token monitor: records each new token and flags overlap or missing gaps.
  always @(negedge clk) begin
    if ($countones(tok) > 1) prot_err = prot_err + 1;
    if (prev_tok != 5'd0 && tok != 5'd0 && tok != prev_tok) prot_err = prot_err + 1;
    if (tok != 5'd0 && tok != prev_tok) begin
      for (int t = 0; t < 5; t++) if (tok[t]) seen.push_back(3'(t));
    end
    prev_tok = tok;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [14:0] exp);
    logic [14:0] got;
    got = '1;
    if (seen.size() >= 5) begin
      got = '0;
      for (int i = 0; i < 5; i++) got = {got[11:0], seen.pop_front()};
    end
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    seen.delete();
    reset = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] mask, input int cycles);
    @(negedge clk);
    ev = mask;
    repeat (cycles) @(negedge clk);
    ev = 4'b0000;
  endtask

  task automatic wait_tok(input int t, input string tag);
    int n;
    n = 0;
    while (!tok[t] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tok[t]), 32'd1);
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n;
    n = 0;
    while (frames_sent != CNT_W'(target) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frames_sent), 32'(target));
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    prot_err = 0;
    prev_tok = '0;
    reset    = 1'b0;
    ev       = '0;
    man_ack  = '0;
    auto_ack = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_tokens", 32'(tok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);

    // Ch2Up: pending at E0, Fs high after E1
    auto_ack = 1'b1;
    @(negedge clk);
    ev = 4'b0100;
    @(negedge clk);
    ev = 4'b0000;
    check("ch2up_e0_tokens", 32'(tok), 32'd0);
    check("ch2up_e0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("ch2up_e1_fs", 32'(tok), 32'b00001);
    check("ch2up_e1_busy", 32'(busy), 32'd1);
    wait_frames(1, "ch2up_frames");
    check_frame("ch2up_seq", F_CH2UP);
    check("ch2up_busy_after", 32'(busy), 32'd0);
    check("ch2up_overflow", 32'(overflow), 32'd0);

    // Ch1Down
    pulse(4'b0010, 1);
    wait_frames(2, "ch1down_frames");
    check_frame("ch1down_seq", F_CH1DOWN);

    // All four in one cycle after reset: round-robin from Ch1Up
    do_reset();
    pulse(4'b1111, 1);
    wait_frames(4, "all4_frames");
    check_frame("all4_f0", F_CH1UP);
    check_frame("all4_f1", F_CH1DOWN);
    check_frame("all4_f2", F_CH2UP);
    check_frame("all4_f3", F_CH2DOWN);
    check("all4_overflow", 32'(overflow), 32'd0);

    // Ch1Up pulsed on E0 and again on its own grant cycle: both kept
    do_reset();
    pulse(4'b0001, 2);
    wait_frames(2, "regrant_frames");
    check_frame("regrant_f0", F_CH1UP);
    check_frame("regrant_f1", F_CH1UP);
    check("regrant_overflow", 32'(overflow), 32'd0);

    // Overflow while stalled on an unacked Fs
    do_reset();
    auto_ack = 1'b0;
    pulse(4'b1000, 1);
    wait_tok(0, "ovf_fs_up");
    pulse(4'b0001, 1);
    check("ovf_first_pulse", 32'(overflow), 32'd0);
    pulse(4'b0001, 1);
    check("ovf_second_pulse", 32'(overflow), 32'd1);
    check("ovf_stalled_fs", 32'(tok), 32'b00001);
    auto_ack = 1'b1;
    wait_frames(2, "ovf_frames");
    repeat (150) @(negedge clk);
    check("ovf_no_extra", 32'(frames_sent), 32'd2);
    check_frame("ovf_f0", F_CH2DOWN);
    check_frame("ovf_f1", F_CH1UP);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Wrong ack ignored; right ack seen two edges late, token drops on the third
    do_reset();
    auto_ack = 1'b0;
    pulse(4'b0001, 1);
    wait_tok(0, "wack_fs_up");
    man_ack = 5'b00010;
    repeat (6) @(negedge clk);
    check("wack_fs_held", 32'(tok), 32'b00001);
    check("wack_no_advance", 32'(frames_sent), 32'd0);
    man_ack = 5'b00001;
    @(negedge clk);
    check("wack_sync1", 32'(tok), 32'b00001);
    @(negedge clk);
    check("wack_sync2", 32'(tok), 32'b00001);
    @(negedge clk);
    check("wack_fs_drop", 32'(tok), 32'b00000);
    man_ack  = 5'b00000;
    auto_ack = 1'b1;
    wait_frames(1, "wack_frames");
    check_frame("wack_seq", F_CH1UP);

    // Reset while One is high mid-frame
    do_reset();
    pulse(4'b0100, 1);
    wait_tok(3, "midrst_one_up");
    reset = 1'b0;
    @(negedge clk);
    check("midrst_tokens", 32'(tok), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frames", 32'(frames_sent), 32'd0);
    reset = 1'b1;
    seen.delete();
    repeat (100) @(negedge clk);
    check("midrst_idle_frames", 32'(frames_sent), 32'd0);
    check("midrst_no_tokens", 32'(seen.size()), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    check("token_protocol", 32'(prot_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aer_frame_encoder.md
Name: aer_frame_encoder

Overview:
- Transmit end of the four-channel AER link; the OutputDecoder is the receive end.
- Latches channel events (Ch1Up, Ch1Down, Ch2Up, Ch2Down) and arbitrates among them round-robin.
- Serialises each granted event as a 5-token frame on the 1-of-5 token wires (Fs, X0, Zero, One, Fe).
- Each token uses a four-phase return-to-zero handshake against its per-token ack.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each incoming ack (min 2)
CNT_W, 16, width of frames_sent counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
Ch1Up  in  1  single-cycle event pulse, clk-synchronous
Ch1Down  in  1  single-cycle event pulse
Ch2Up  in  1  single-cycle event pulse
Ch2Down  in  1  single-cycle event pulse
Fs  out  1  frame-start token
X0  out  1  separator token
Zero  out  1  data-0 token
One  out  1  data-1 token
Fe  out  1  frame-end token
Fs_ack  in  1  async ack for Fs
X0_ack  in  1  async ack for X0
Zero_ack  in  1  async ack for Zero
One_ack  in  1  async ack for One
Fe_ack  in  1  async ack for Fe
busy  out  1  frame in progress
overflow  out  1  sticky: event lost
frames_sent  out  CNT_W  completed frames, wraps at 2^CNT_W

Behaviour:
- Reset (reset==0 at an edge): all token outputs 0, busy 0, overflow 0, frames_sent 0, pending flags 0, RR pointer = Ch1Up, FSM = IDLE, synchronisers cleared. Reset mid-frame aborts the frame at the next edge; the system resets the decoder with it.
- Frame format, in order: Fs, channel bit (Zero = Ch1, One = Ch2), X0, direction bit (Zero = Down, One = Up), Fe.
  - Example: Ch2Up -> Fs, One, X0, One, Fe.
- Pending latches, one per event:
  - Set on its input pulse.
  - Cleared when that event is granted.
  - If a pulse arrives on the grant cycle of the same event, the flag stays set (the new event is kept).
  - If a pulse arrives while the flag is set and not being granted, the event is dropped and overflow is set (stays 1 until reset).
- Arbitration:
  - Fixed order Ch1Up, Ch1Down, Ch2Up, Ch2Down.
  - Search starts at the RR pointer; after a grant the pointer moves to the entry after the granted one, wrapping.
  - Grant occurs only in IDLE.
- FSM:
  - IDLE: if any pending, grant, load the 5-token frame, token index = 0, go ASSERT. busy is 1 from ASSERT entry until return to IDLE.
  - ASSERT: drive exactly the current token wire high. Wait until the synchronised ack of that token is 1; then go RELEASE. Acks of other tokens are ignored.
  - RELEASE: all token wires 0. Wait until the synchronised ack of the current token is 0.
    - If the index is < 4: index +1, go ASSERT.
    - Else: frames_sent +1, go IDLE.
- Timing:
  - Pulse sampled at edge E0 sets pending.
  - Grant at E1; Fs goes high after E1.
  - Ack rise is seen SYNC_STAGES edges after it occurs; the token drops on the following edge.
  - At most one token wire is high in any cycle. All token wires are low for at least one cycle between tokens.
- No timeout: a missing ack stalls the FSM indefinitely. Events keep latching during the stall; overflow flags any losses.
- Back-to-back frames: the FSM returns to IDLE for one cycle before the next Fs.
- Outputs are registered; no combinational path from ack to token.

Test Plan:
- Ch2Up pulse, bench acks each token 3 cycles after it rises and drops ack 3 cycles after the token falls -> tokens seen Fs, One, X0, One, Fe; frames_sent = 1; busy low afterwards; overflow 0.
- Ch1Down pulse -> token sequence Fs, Zero, X0, Zero, Fe.
- All four pulses in the same cycle after reset -> frames in order Ch1Up, Ch1Down, Ch2Up, Ch2Down; frames_sent = 4; overflow 0.
- Ch1Up pulsed twice while the FSM is stalled on an unacked Fs -> overflow = 1. Release ack -> exactly one Ch1Up frame follows the current frame.
- Assert a wrong ack (X0_ack while Fs is high) -> Fs stays high; FSM does not advance until Fs_ack.
- Drive reset low while One is high mid-frame -> next edge: all tokens 0, busy 0, frames_sent 0. With no new events after release, no frame is sent.
